// File: rtl/dshot_multi_output.sv
// dshot_multi_output
//   Multi-channel DSHOT150/300/600 transmitter. Each channel owns an
//   independent IDLE/HIGH/LOW/GUARD state machine, a 4-bit bit counter,
//   a cycle counter and a one-deep pending-frame buffer. A frame is built
//   from an 11-bit throttle value, a telemetry bit and a 4-bit checksum,
//   and is sent MSB first.
//
// Ports
//   i_clk         sole clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_throttle    CHANNELS x 11-bit throttle/command, channel n at [n*11 +: 11]
//   i_telem       per-channel telemetry-request bit
//   i_write       per-channel single-cycle write strobe
//   i_dshot_mode  shared rate select: 150, 300 or 600 (anything else ignored)
//   o_pwm         per-channel DSHOT line, idle low
//   o_ready       per-channel: idle with nothing pending
//   o_pending     per-channel: a buffered frame awaits transmission
//   o_done        per-channel one-cycle pulse when the guard time ends
module dshot_multi_output #(
  parameter int CHANNELS       = 4,
  parameter int clockFrequency = 72_000_000,
  parameter int GUARD_US       = 250
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [CHANNELS*11-1:0]   i_throttle,
  input  logic [CHANNELS-1:0]      i_telem,
  input  logic [CHANNELS-1:0]      i_write,
  input  logic [15:0]              i_dshot_mode,
  output logic [CHANNELS-1:0]      o_pwm,
  output logic [CHANNELS-1:0]      o_ready,
  output logic [CHANNELS-1:0]      o_pending,
  output logic [CHANNELS-1:0]      o_done
);

  localparam int BIT_150   = clockFrequency / (150 * 1000);
  localparam int BIT_300   = clockFrequency / (300 * 1000);
  localparam int BIT_600   = clockFrequency / (600 * 1000);
  localparam int GUARD_CYC = clockFrequency / 1_000_000 * GUARD_US;
  // BIT_150 is the longest bit time; every high time is shorter than it.
  localparam int MAX_CYC   = (GUARD_CYC > BIT_150) ? GUARD_CYC : BIT_150;
  localparam int CW        = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] GUARD_M1 = CW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  // Frame = {throttle, telem, crc}; crc folds the three nibbles of the 12-bit payload.
  function automatic logic [15:0] build_frame(input logic [10:0] thr, input logic tel);
    logic [11:0] v12;
    logic [11:0] mix;
    v12 = {thr, tel};
    mix = v12 ^ (v12 >> 4) ^ (v12 >> 8);
    return {v12, mix[3:0]};
  endfunction

  // Full bit period for the selected rate.
  function automatic logic [CW-1:0] bit_len(input logic [1:0] sel);
    logic [CW-1:0] len;
    case (sel)
      2'd0:    len = CW'(BIT_150);
      2'd1:    len = CW'(BIT_300);
      2'd2:    len = CW'(BIT_600);
      default: len = CW'(BIT_150);
    endcase
    return len;
  endfunction

  // High time of one bit: 3/4 of the period for a one, 3/8 for a zero.
  function automatic logic [CW-1:0] high_len(input logic [1:0] sel, input logic b);
    logic [CW-1:0] len;
    case (sel)
      2'd0:    len = b ? CW'(BIT_150 * 3 / 4) : CW'(BIT_150 * 3 / 8);
      2'd1:    len = b ? CW'(BIT_300 * 3 / 4) : CW'(BIT_300 * 3 / 8);
      2'd2:    len = b ? CW'(BIT_600 * 3 / 4) : CW'(BIT_600 * 3 / 8);
      default: len = b ? CW'(BIT_150 * 3 / 4) : CW'(BIT_150 * 3 / 8);
    endcase
    return len;
  endfunction

  logic [1:0] mode_sel_s;
  logic       mode_ok_s;

  // Decode the shared rate select; an unknown rate makes every write a no-op.
  always_comb begin
    mode_sel_s = 2'd0;
    mode_ok_s  = 1'b0;
    case (i_dshot_mode)
      16'd150: begin mode_sel_s = 2'd0; mode_ok_s = 1'b1; end
      16'd300: begin mode_sel_s = 2'd1; mode_ok_s = 1'b1; end
      16'd600: begin mode_sel_s = 2'd2; mode_ok_s = 1'b1; end
      default: begin mode_sel_s = 2'd0; mode_ok_s = 1'b0; end
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    bit_r, bit_s;
    logic [15:0]   frame_r, frame_s;
    logic [1:0]    msel_r, msel_s;
    logic [15:0]   pend_frame_r, pend_frame_s;
    logic [1:0]    pend_msel_r, pend_msel_s;
    logic          pend_r, pend_s;
    logic          pwm_r, pwm_s;
    logic          done_r, done_s;
    logic          ready_r, ready_s;
    logic          wr_s;
    logic [15:0]   new_frame_s;
    logic [CW-1:0] bit_len_s, hi_len_s;

    // Next-state logic. The active frame shifts left so bit 15 is always the bit on the wire,
    // and the rate captured at load time (msel_r) governs the whole frame and its guard.
    always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      bit_s        = bit_r;
      frame_s      = frame_r;
      msel_s       = msel_r;
      pend_frame_s = pend_frame_r;
      pend_msel_s  = pend_msel_r;
      pend_s       = pend_r;
      pwm_s        = pwm_r;
      done_s       = 1'b0;
      wr_s         = i_write[g] & mode_ok_s;
      new_frame_s  = build_frame(i_throttle[g*11 +: 11], i_telem[g]);
      bit_len_s    = bit_len(msel_r);
      hi_len_s     = high_len(msel_r, frame_r[15]);

      case (state_r)
        ST_IDLE: begin
          if (wr_s) begin
            frame_s = new_frame_s;
            msel_s  = mode_sel_s;
            cnt_s   = CNT_ZERO;
            bit_s   = 4'd0;
            state_s = ST_HIGH;
            pwm_s   = 1'b1;
          end else begin
            pwm_s = 1'b0;
          end
        end
        ST_HIGH: begin
          if (wr_s) begin
            pend_frame_s = new_frame_s;
            pend_msel_s  = mode_sel_s;
            pend_s       = 1'b1;
          end else begin
            pend_s = pend_r;
          end
          if (cnt_r == hi_len_s - CNT_ONE) begin
            state_s = ST_LOW;
            pwm_s   = 1'b0;
          end else begin
            pwm_s = 1'b1;
          end
          cnt_s = cnt_r + CNT_ONE;
        end
        ST_LOW: begin
          pwm_s = 1'b0;
          if (wr_s) begin
            pend_frame_s = new_frame_s;
            pend_msel_s  = mode_sel_s;
            pend_s       = 1'b1;
          end else begin
            pend_s = pend_r;
          end
          if (cnt_r == bit_len_s - CNT_ONE) begin
            cnt_s = CNT_ZERO;
            if (bit_r == 4'd15) begin
              state_s = ST_GUARD;
            end else begin
              bit_s   = bit_r + 4'd1;
              frame_s = {frame_r[14:0], 1'b0};
              state_s = ST_HIGH;
              pwm_s   = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_GUARD: begin
          pwm_s = 1'b0;
          if (cnt_r == GUARD_M1) begin
            // A write on the last guard cycle goes straight out, beating the buffer.
            done_s = 1'b1;
            cnt_s  = CNT_ZERO;
            bit_s  = 4'd0;
            pend_s = 1'b0;
            if (wr_s) begin
              frame_s = new_frame_s;
              msel_s  = mode_sel_s;
              state_s = ST_HIGH;
              pwm_s   = 1'b1;
            end else if (pend_r) begin
              frame_s = pend_frame_r;
              msel_s  = pend_msel_r;
              state_s = ST_HIGH;
              pwm_s   = 1'b1;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            if (wr_s) begin
              pend_frame_s = new_frame_s;
              pend_msel_s  = mode_sel_s;
              pend_s       = 1'b1;
            end else begin
              pend_s = pend_r;
            end
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          bit_s   = 4'd0;
          pend_s  = 1'b0;
          pwm_s   = 1'b0;
        end
      endcase

      ready_s = (state_s == ST_IDLE) && !pend_s;
    end

    // Channel state and registered outputs; reset forces the line low immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state_r      <= ST_IDLE;
        cnt_r        <= CNT_ZERO;
        bit_r        <= 4'd0;
        frame_r      <= 16'd0;
        msel_r       <= 2'd0;
        pend_frame_r <= 16'd0;
        pend_msel_r  <= 2'd0;
        pend_r       <= 1'b0;
        pwm_r        <= 1'b0;
        done_r       <= 1'b0;
        ready_r      <= 1'b1;
      end else begin
        state_r      <= state_s;
        cnt_r        <= cnt_s;
        bit_r        <= bit_s;
        frame_r      <= frame_s;
        msel_r       <= msel_s;
        pend_frame_r <= pend_frame_s;
        pend_msel_r  <= pend_msel_s;
        pend_r       <= pend_s;
        pwm_r        <= pwm_s;
        done_r       <= done_s;
        ready_r      <= ready_s;
      end
    end

    assign o_pwm[g]     = pwm_r;
    assign o_ready[g]   = ready_r;
    assign o_pending[g] = pend_r;
    assign o_done[g]    = done_r;
  end

endmodule

// File: tb/tb_dshot_multi_output.sv
// tb_dshot_multi_output
//   Scoreboard bench for dshot_multi_output (4 channels, 72 MHz, 250 us guard).
//   Each accepted write pushes {bit_period, frame} onto the channel queue
//   (a write to a busy channel replaces the buffered entry); a negedge monitor
//   decodes every pulse, checks high times and periods against the queue head,
//   and pops/compares the frame and guard time on o_done.
module tb_dshot_multi_output;

  localparam int CH       = 4;
  localparam int CLK_HZ   = 72_000_000;
  localparam int GUARD_US = 250;
  localparam int GUARD_CYC = CLK_HZ / 1_000_000 * GUARD_US;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [CH*11-1:0]  i_throttle = '0;
  logic [CH-1:0]     i_telem = '0;
  logic [CH-1:0]     i_write = '0;
  logic [15:0]       i_dshot_mode = 16'd150;
  logic [CH-1:0]     o_pwm, o_ready, o_pending, o_done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [31:0] sb_q [CH][$];

  dshot_multi_output #(
    .CHANNELS(CH), .clockFrequency(CLK_HZ), .GUARD_US(GUARD_US)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_throttle(i_throttle),
    .i_telem(i_telem), .i_write(i_write), .i_dshot_mode(i_dshot_mode),
    .o_pwm(o_pwm), .o_ready(o_ready), .o_pending(o_pending), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [10:0] thr, input logic tel);
    logic [11:0] v;
    logic [3:0]  c;
    v = {thr, tel};
    c = v[3:0] ^ v[7:4] ^ v[11:8];
    return {v, c};
  endfunction

  // Drive one write strobe (called just after a negedge) and record expectations.
  task automatic do_write(input logic [CH-1:0] mask, input logic [15:0] mode);
    int          bitc;
    logic [31:0] ent;
    i_dshot_mode = mode;
    i_write = mask;
    if (mode == 16'd150 || mode == 16'd300 || mode == 16'd600) begin
      bitc = CLK_HZ / (int'(mode) * 1000);
      for (int c = 0; c < CH; c++) begin
        if (mask[c]) begin
          ent = {bitc[15:0], model_frame(i_throttle[c*11 +: 11], i_telem[c])};
          if (sb_q[c].size() >= 2) sb_q[c][1] = ent;
          else sb_q[c].push_back(ent);
        end
      end
    end
    @(negedge i_clk);
    i_write = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      @(negedge i_clk);
      n++;
      busy = (o_ready !== 4'hF);
      for (int c = 0; c < CH; c++) if (sb_q[c].size() != 0) busy = 1'b1;
    end
    check(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Pulse monitor / scoreboard consumer.
  int          bit_idx [CH];
  int          last_rise [CH];
  logic [15:0] acc [CH];
  logic [31:0] cur [CH];
  logic        prev [CH];

  initial begin
    for (int c = 0; c < CH; c++) begin
      bit_idx[c] = 0; last_rise[c] = 0; acc[c] = 16'd0; cur[c] = 32'd0; prev[c] = 1'b0;
    end
    forever begin
      @(negedge i_clk);
      for (int c = 0; c < CH; c++) begin
        if (!i_reset_n) begin
          bit_idx[c] = 0; acc[c] = 16'd0; prev[c] = 1'b0;
        end else begin
          if (o_done[c]) begin
            check("done_after_16_bits", bit_idx[c], 32'd16);
            if (sb_q[c].size() > 0) begin
              logic [31:0] ent;
              ent = sb_q[c].pop_front();
              check("frame", {16'd0, acc[c]}, {16'd0, ent[15:0]});
              check("guard_time", cyc - last_rise[c], int'(ent[31:16]) + GUARD_CYC);
            end else begin
              check("done_unexpected", sb_q[c].size(), 32'd1);
            end
            bit_idx[c] = 0;
            acc[c] = 16'd0;
          end
          if (o_pwm[c] && !prev[c]) begin
            if (bit_idx[c] == 0) begin
              check("rise_expected", (sb_q[c].size() > 0) ? 32'd1 : 32'd0, 32'd1);
              if (sb_q[c].size() > 0) cur[c] = sb_q[c][0];
            end else if (bit_idx[c] < 16) begin
              check("bit_period", cyc - last_rise[c], {16'd0, cur[c][31:16]});
            end else begin
              check("rise_in_guard", bit_idx[c], 32'd0);
            end
            last_rise[c] = cyc;
          end
          if (!o_pwm[c] && prev[c] && bit_idx[c] < 16) begin
            int   hi, bitc;
            logic expb;
            hi   = cyc - last_rise[c];
            bitc = int'(cur[c][31:16]);
            expb = cur[c][15 - bit_idx[c]];
            check("high_time", hi, expb ? bitc * 3 / 4 : bitc * 3 / 8);
            acc[c] = {acc[c][14:0], (hi == bitc * 3 / 4)};
            bit_idx[c]++;
          end
          prev[c] = o_pwm[c];
        end
      end
    end
  end

  initial begin
    int kA, n_frame, quiet;

    // Reset state.
    #23;
    check("rst_pwm", {28'd0, o_pwm}, 32'd0);
    check("rst_pending", {28'd0, o_pending}, 32'd0);
    check("rst_done", {28'd0, o_done}, 32'd0);
    check("rst_ready", {28'd0, o_ready}, 32'hF);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);

    // Mode 150 on ch0 (0x0000) and ch1 (1000 -> 0x7D0A), mode 300 and 600 on ch2/ch3
    // with all-ones frames; the mode input then changes while they run.
    i_throttle[0*11 +: 11] = 11'd0;    i_telem[0] = 1'b0;
    i_throttle[1*11 +: 11] = 11'd1000; i_telem[1] = 1'b0;
    i_throttle[2*11 +: 11] = 11'd2047; i_telem[2] = 1'b1;
    i_throttle[3*11 +: 11] = 11'd2047; i_telem[3] = 1'b1;
    do_write(4'b0011, 16'd150);
    check("latency_ch01", {30'd0, o_pwm[1:0]}, 32'd3);
    do_write(4'b0100, 16'd300);
    do_write(4'b1000, 16'd600);
    i_dshot_mode = 16'd150;
    repeat (500) @(negedge i_clk);
    i_dshot_mode = 16'd600;
    wait_idle("idle_after_rates", 30000);

    // Invalid rate: no activity at all.
    quiet = 0;
    do_write(4'hF, 16'd200);
    repeat (50) begin
      @(negedge i_clk);
      if (o_pwm != 4'h0 || o_ready != 4'hF || o_pending != 4'h0) quiet++;
    end
    check("invalid_mode_quiet", quiet, 32'd0);

    // Four channels written together at 600; ch0/ch1 exercise the pending buffer.
    i_throttle[0*11 +: 11] = 11'd100;  i_telem[0] = 1'b0;
    i_throttle[1*11 +: 11] = 11'd200;  i_telem[1] = 1'b1;
    i_throttle[2*11 +: 11] = 11'd2047; i_telem[2] = 1'b1;
    i_throttle[3*11 +: 11] = 11'd5;    i_telem[3] = 1'b0;
    check("pre_write_low", {28'd0, o_pwm}, 32'd0);
    do_write(4'hF, 16'd600);
    kA = cyc;
    check("same_cycle_rise", {28'd0, o_pwm}, 32'hF);
    n_frame = 16 * (CLK_HZ / 600_000) + GUARD_CYC;
    repeat (300) @(negedge i_clk);
    i_throttle[0*11 +: 11] = 11'd300; i_throttle[1*11 +: 11] = 11'd400;
    do_write(4'b0011, 16'd600);
    check("pending_after_B", {30'd0, o_pending[1:0]}, 32'd3);
    repeat (300) @(negedge i_clk);
    i_throttle[0*11 +: 11] = 11'd500; i_throttle[1*11 +: 11] = 11'd600;
    do_write(4'b0011, 16'd600);
    i_throttle[0*11 +: 11] = 11'd777;
    do_write(4'b0001, 16'd200);
    check("pending_after_invalid", {30'd0, o_pending[1:0]}, 32'd3);
    i_throttle[1*11 +: 11] = 11'd1500; i_telem[1] = 1'b0;
    while (cyc < kA + n_frame - 1) @(negedge i_clk);
    check("pending_before_D", {31'd0, o_pending[1]}, 32'd1);
    do_write(4'b0010, 16'd600);
    check("pending_clear_after_guard", {30'd0, o_pending[1:0]}, 32'd0);
    wait_idle("idle_after_pending", 45000);

    // Reset during bit 7 with a frame buffered.
    i_throttle[0*11 +: 11] = 11'd1234; i_telem[0] = 1'b0;
    do_write(4'b0001, 16'd150);
    repeat (3400) @(negedge i_clk);
    i_throttle[0*11 +: 11] = 11'd99;
    do_write(4'b0001, 16'd150);
    check("pending_before_reset", {31'd0, o_pending[0]}, 32'd1);
    check("pwm_high_before_reset", {31'd0, o_pwm[0]}, 32'd1);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    for (int c = 0; c < CH; c++) sb_q[c].delete();
    #1;
    check("reset_pwm_async", {28'd0, o_pwm}, 32'd0);
    check("reset_pending", {28'd0, o_pending}, 32'd0);
    check("reset_ready", {28'd0, o_ready}, 32'hF);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    quiet = 0;
    repeat (2000) begin
      @(negedge i_clk);
      if (o_pwm != 4'h0 || o_done != 4'h0) quiet++;
    end
    check("post_reset_quiet", quiet, 32'd0);
    check("post_reset_ready", {28'd0, o_ready}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
